// File: rtl/pipe_pkg.sv
// Shared types for the five-stage pipeline sequencing controller.
// The stage_ctrl_t bundle lets the stage registers take one control input.
package pipe_pkg;

  typedef enum logic [1:0] {
    StRun,
    StStall,
    StFreeze,
    StRedirect
  } pipe_st_t;

  typedef struct packed {
    logic pc_we;
    logic pc_sel;
    logic if_rr_we;
    logic rr_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_rr_flush;
    logic rr_ex_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CtrlOff = '0;

  localparam stage_ctrl_t CtrlRedirect = '{
    pc_we: 1'b1, pc_sel: 1'b1, if_rr_we: 1'b1, rr_ex_we: 1'b1,
    ex_mem_we: 1'b1, mem_wb_we: 1'b1, if_rr_flush: 1'b1, rr_ex_flush: 1'b1
  };

  localparam stage_ctrl_t CtrlStall = '{
    pc_we: 1'b0, pc_sel: 1'b0, if_rr_we: 1'b0, rr_ex_we: 1'b1,
    ex_mem_we: 1'b1, mem_wb_we: 1'b1, if_rr_flush: 1'b0, rr_ex_flush: 1'b1
  };

  localparam stage_ctrl_t CtrlFetchBubble = '{
    pc_we: 1'b0, pc_sel: 1'b0, if_rr_we: 1'b1, rr_ex_we: 1'b1,
    ex_mem_we: 1'b1, mem_wb_we: 1'b1, if_rr_flush: 1'b1, rr_ex_flush: 1'b0
  };

  localparam stage_ctrl_t CtrlNormal = '{
    pc_we: 1'b1, pc_sel: 1'b0, if_rr_we: 1'b1, rr_ex_we: 1'b1,
    ex_mem_we: 1'b1, mem_wb_we: 1'b1, if_rr_flush: 1'b0, rr_ex_flush: 1'b0
  };

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a synchronous clear that beats increment.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: turns hazard, branch and memory-wait inputs into
// per-stage write-enables/flushes, plus perf counters and a stuck-interlock watchdog.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CntW    = 16,
  parameter int unsigned LockMax = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            h_lock_i,
  input  logic            br_taken_ex_i,
  input  logic            if_busy_i,
  input  logic            mem_busy_i,
  input  logic            cnt_clr_i,
  output logic            pc_we_o,
  output logic            pc_sel_o,
  output logic            if_rr_we_o,
  output logic            rr_ex_we_o,
  output logic            ex_mem_we_o,
  output logic            mem_wb_we_o,
  output logic            if_rr_flush_o,
  output logic            rr_ex_flush_o,
  output logic [CntW-1:0] stall_cnt_o,
  output logic [CntW-1:0] freeze_cnt_o,
  output logic [CntW-1:0] flush_cnt_o,
  output logic            lock_err_o
);

  localparam int unsigned RunW = $clog2(LockMax + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(LockMax);

  pipe_st_t    state_q, state_d;
  stage_ctrl_t ctrl, ctrl_out;
  logic        stall_ev, freeze_ev, flush_ev;

  logic [RunW-1:0] lock_run_q, lock_run_d;
  logic            lock_err_q, lock_err_d;

  // Priority-ordered Mealy decode; first matching condition wins.
  always_comb begin
    ctrl      = CtrlNormal;
    state_d   = StRun;
    stall_ev  = 1'b0;
    freeze_ev = 1'b0;
    flush_ev  = 1'b0;
    if (mem_busy_i) begin
      ctrl      = CtrlOff;
      state_d   = StFreeze;
      freeze_ev = 1'b1;
    end else if (br_taken_ex_i) begin
      ctrl     = CtrlRedirect;
      state_d  = StRedirect;
      flush_ev = 1'b1;
    end else if (h_lock_i && (state_q != StRedirect)) begin
      // After a redirect RR holds a bubble, so its interlock request is bogus.
      ctrl     = CtrlStall;
      state_d  = StStall;
      stall_ev = 1'b1;
    end else if (if_busy_i) begin
      ctrl = CtrlFetchBubble;
    end
  end

  // Enables are forced off for the whole reset window, not just after the edge.
  assign ctrl_out = rst_ni ? ctrl : CtrlOff;

  assign pc_we_o       = ctrl_out.pc_we;
  assign pc_sel_o      = ctrl_out.pc_sel;
  assign if_rr_we_o    = ctrl_out.if_rr_we;
  assign rr_ex_we_o    = ctrl_out.rr_ex_we;
  assign ex_mem_we_o   = ctrl_out.ex_mem_we;
  assign mem_wb_we_o   = ctrl_out.mem_wb_we;
  assign if_rr_flush_o = ctrl_out.if_rr_flush;
  assign rr_ex_flush_o = ctrl_out.rr_ex_flush;

  // Freeze cycles hold the run length so a stall split by a memory wait still counts.
  always_comb begin
    lock_run_d = lock_run_q;
    lock_err_d = lock_err_q;
    if (stall_ev) begin
      if (lock_run_q != RunMax) begin
        lock_run_d = lock_run_q + 1'b1;
      end
      if (lock_run_d == RunMax) begin
        lock_err_d = 1'b1;
      end
    end else if (!freeze_ev) begin
      lock_run_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StRun;
      lock_run_q <= '0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_run_q <= lock_run_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign lock_err_o = lock_err_q;

  sat_counter #(
    .Width (CntW)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (stall_ev),
    .clr_i  (cnt_clr_i),
    .cnt_o  (stall_cnt_o)
  );

  sat_counter #(
    .Width (CntW)
  ) u_freeze_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (freeze_ev),
    .clr_i  (cnt_clr_i),
    .cnt_o  (freeze_cnt_o)
  );

  sat_counter #(
    .Width (CntW)
  ) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (flush_ev),
    .clr_i  (cnt_clr_i),
    .cnt_o  (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: truth-table vectors, directed corner sequences
// and random traffic compared against a rule-level reference model.
module tb_pipe_ctrl;

  localparam int CW  = 4;
  localparam int LM  = 8;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic h_lock = 1'b0, br = 1'b0, if_busy = 1'b0, mem_busy = 1'b0, cnt_clr = 1'b0;
  logic pc_we, pc_sel, if_rr_we, rr_ex_we, ex_mem_we, mem_wb_we, if_rr_flush, rr_ex_flush;
  logic [CW-1:0] stall_cnt, freeze_cnt, flush_cnt;
  logic lock_err;

  pipe_ctrl #(
    .CntW    (CW),
    .LockMax (LM)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .h_lock_i      (h_lock),
    .br_taken_ex_i (br),
    .if_busy_i     (if_busy),
    .mem_busy_i    (mem_busy),
    .cnt_clr_i     (cnt_clr),
    .pc_we_o       (pc_we),
    .pc_sel_o      (pc_sel),
    .if_rr_we_o    (if_rr_we),
    .rr_ex_we_o    (rr_ex_we),
    .ex_mem_we_o   (ex_mem_we),
    .mem_wb_we_o   (mem_wb_we),
    .if_rr_flush_o (if_rr_flush),
    .rr_ex_flush_o (rr_ex_flush),
    .stall_cnt_o   (stall_cnt),
    .freeze_cnt_o  (freeze_cnt),
    .flush_cnt_o   (flush_cnt),
    .lock_err_o    (lock_err)
  );

  always #5 clk = ~clk;

  // {pc_we, pc_sel, if_rr_we, rr_ex_we, ex_mem_we, mem_wb_we, if_rr_flush, rr_ex_flush}
  logic [7:0] act_ctrl;
  assign act_ctrl = {pc_we, pc_sel, if_rr_we, rr_ex_we, ex_mem_we, mem_wb_we,
                     if_rr_flush, rr_ex_flush};

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  bit m_redir;
  int m_stall, m_freeze, m_flush, m_run;
  bit m_err;

  typedef struct {
    logic [3:0] in;   // {mem_busy, br_taken_ex, h_lock, if_busy}
    logic [7:0] want;
  } vec_t;

  function automatic int rule_of(logic [3:0] in, bit redir);
    if (in[3]) return 1;
    if (in[2]) return 2;
    if (in[1] && !redir) return 3;
    if (in[0]) return 4;
    return 5;
  endfunction

  function automatic logic [7:0] exp_of(int r);
    case (r)
      1: return 8'h00;
      2: return 8'hFF;
      3: return 8'h1D;
      4: return 8'h3E;
      default: return 8'hBC;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d (0x%0h) want %0d (0x%0h)", name, $time, act, act,
               want, want);
    end
  endtask

  task automatic model_reset();
    m_redir  = 1'b0;
    m_stall  = 0;
    m_freeze = 0;
    m_flush  = 0;
    m_run    = 0;
    m_err    = 1'b0;
  endtask

  // One clock cycle: drive, check Mealy outputs, clock, check registered state.
  task automatic step(input logic [3:0] in, input logic clr, input bit use_want,
                      input logic [7:0] want);
    int r;
    {mem_busy, br, h_lock, if_busy} = in;
    cnt_clr = clr;
    #1;
    r = rule_of(in, m_redir);
    chk("ctrl", int'(act_ctrl), int'(exp_of(r)));
    if (use_want) chk("table_ctrl", int'(act_ctrl), int'(want));
    @(posedge clk);
    if (clr) begin
      m_stall = 0; m_freeze = 0; m_flush = 0;
    end else begin
      if (r == 3 && m_stall  < SAT) m_stall++;
      if (r == 1 && m_freeze < SAT) m_freeze++;
      if (r == 2 && m_flush  < SAT) m_flush++;
    end
    if (r == 3) begin
      m_run++;
      if (m_run >= LM) m_err = 1'b1;
    end else if (r != 1) begin
      m_run = 0;
    end
    m_redir = (r == 2);
    #1;
    chk("stall_cnt", int'(stall_cnt), m_stall);
    chk("freeze_cnt", int'(freeze_cnt), m_freeze);
    chk("flush_cnt", int'(flush_cnt), m_flush);
    chk("lock_err", int'(lock_err), int'(m_err));
  endtask

  task automatic go(input logic [3:0] in, input logic clr);
    step(in, clr, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    {mem_busy, br, h_lock, if_busy} = 4'b0111;
    cnt_clr = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("reset_ctrl", int'(act_ctrl), 0);
    chk("reset_stall_cnt", int'(stall_cnt), 0);
    chk("reset_freeze_cnt", int'(freeze_cnt), 0);
    chk("reset_flush_cnt", int'(flush_cnt), 0);
    chk("reset_lock_err", int'(lock_err), 0);
    {mem_busy, br, h_lock, if_busy} = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t tbl[$];

  initial begin
    model_reset();
    tbl.push_back('{4'b0000, 8'hBC});
    tbl.push_back('{4'b0001, 8'h3E});
    tbl.push_back('{4'b0010, 8'h1D});
    tbl.push_back('{4'b0011, 8'h1D});
    tbl.push_back('{4'b0100, 8'hFF});
    tbl.push_back('{4'b0110, 8'hFF});
    tbl.push_back('{4'b0111, 8'hFF});
    tbl.push_back('{4'b1000, 8'h00});
    tbl.push_back('{4'b1110, 8'h00});
    tbl.push_back('{4'b1111, 8'h00});

    do_reset();

    // Truth table, each vector applied from RUN
    foreach (tbl[i]) begin
      go(4'b0000, 1'b0);
      step(tbl[i].in, 1'b0, 1'b1, tbl[i].want);
    end

    // Idle
    do_reset();
    repeat (3) step(4'b0000, 1'b0, 1'b1, 8'hBC);
    chk("idle_stall_cnt", int'(stall_cnt), 0);

    // Two-cycle interlock
    step(4'b0010, 1'b0, 1'b1, 8'h1D);
    step(4'b0010, 1'b0, 1'b1, 8'h1D);
    chk("stall2_cnt", int'(stall_cnt), 2);
    step(4'b0000, 1'b0, 1'b1, 8'hBC);

    // Branch with interlock, then interlock ignored in REDIRECT
    go(4'b0000, 1'b1);
    step(4'b0110, 1'b0, 1'b1, 8'hFF);
    step(4'b0010, 1'b0, 1'b1, 8'hBC);
    chk("redir_flush_cnt", int'(flush_cnt), 1);
    chk("redir_stall_cnt", int'(stall_cnt), 0);
    step(4'b0010, 1'b0, 1'b1, 8'h1D);

    // Freeze with pending branch, released into redirect
    go(4'b0000, 1'b1);
    repeat (3) step(4'b1100, 1'b0, 1'b1, 8'h00);
    chk("freeze3_cnt", int'(freeze_cnt), 3);
    step(4'b0100, 1'b0, 1'b1, 8'hFF);

    // Watchdog: rises after the 8th stall, survives cnt_clr, cleared by reset
    do_reset();
    repeat (LM - 1) go(4'b0010, 1'b0);
    chk("wd_before", int'(lock_err), 0);
    go(4'b0010, 1'b0);
    chk("wd_after", int'(lock_err), 1);
    go(4'b0000, 1'b1);
    chk("wd_cnt_clr", int'(lock_err), 1);
    do_reset();
    chk("wd_reset", int'(lock_err), 0);

    // Freeze holds the run length
    repeat (5) go(4'b0010, 1'b0);
    repeat (2) go(4'b1010, 1'b0);
    repeat (3) go(4'b0010, 1'b0);
    chk("wd_freeze_hold", int'(lock_err), 1);

    // Saturation and clear
    do_reset();
    repeat (20) go(4'b0010, 1'b0);
    chk("sat_stall_cnt", int'(stall_cnt), SAT);
    go(4'b0000, 1'b1);
    chk("clr_stall_cnt", int'(stall_cnt), 0);

    // Random traffic with occasional mid-run reset
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] in;
      in[3] = ($urandom_range(99) < 15);
      in[2] = ($urandom_range(99) < 15);
      in[1] = ($urandom_range(99) < 45);
      in[0] = ($urandom_range(99) < 20);
      go(in, ($urandom_range(99) < 3));
      if ((i % 300) == 299) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage segmented core (IF, RR, EX, MEM, WB). It combines the hazard unit's interlock request, the EX-stage branch decision and the instruction/data memory wait signals into per-stage register write-enables, bubble-insert flushes and the PC-redirect select. It also runs stall/freeze/flush performance counters and a stuck-interlock watchdog. It sits between the hazard unit and the stage pipeline registers.

## Interface
- CNT_W, 16: width of each performance counter.
- LOCK_MAX, 8: consecutive `h_lock` stall cycles tolerated before `lock_err` is set.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `h_lock` in 1: load-use interlock request from the hazard unit.
- `br_taken_ex` in 1: branch/jump in EX resolved taken.
- `if_busy` in 1: instruction memory not ready.
- `mem_busy` in 1: data memory access in MEM not complete.
- `cnt_clr` in 1: synchronous clear of all counters.
- `pc_we` out 1: PC register write-enable.
- `pc_sel` out 1: 1 = load branch target, 0 = PC+4.
- `if_rr_we`, `rr_ex_we`, `ex_mem_we`, `mem_wb_we` out 1 each: pipeline register write-enables.
- `if_rr_flush`, `rr_ex_flush` out 1 each: load a NOP bubble into the register (takes effect only when the matching `_we` is 1).
- `stall_cnt`, `freeze_cnt`, `flush_cnt` out CNT_W each: performance counters.
- `lock_err` out 1: sticky watchdog flag.

## Operation
- The FSM states are RUN, STALL, FREEZE and REDIRECT. The state is registered and the outputs are Mealy: state plus current inputs. Outputs are evaluated in the priority order below, and the first match wins.
- Outputs in any state, in priority order:
  1. `mem_busy`=1 → freeze. All `_we`=0, `pc_we`=0, all flushes 0. Next state FREEZE.
  2. `br_taken_ex`=1 → redirect. `pc_we`=1, `pc_sel`=1, all `_we`=1, `if_rr_flush`=1, `rr_ex_flush`=1. Next state REDIRECT.
  3. `h_lock`=1 and state≠REDIRECT → stall. `pc_we`=0, `if_rr_we`=0, `rr_ex_flush`=1, other `_we`=1. Next state STALL.
  4. `if_busy`=1 → fetch bubble. `pc_we`=0, `if_rr_flush`=1, all `_we`=1. Next state RUN.
  5. Otherwise → normal. All `_we`=1, `pc_we`=1, `pc_sel`=0, flushes 0. Next state RUN.
- REDIRECT lasts one cycle. In it `h_lock` is ignored, because RR holds a bubble whose register fields are meaningless. `br_taken_ex` in REDIRECT still follows rule 2, since EX then holds a bubble and the hazard unit cannot produce it.
- FREEZE has no special exit. On the cycle `mem_busy` falls, rules 2–5 apply immediately. The branch or interlock condition held frozen in EX/RR is acted on in that same cycle.
- `stall_cnt` increments on every rule-3 cycle.
- `freeze_cnt` increments on every rule-1 cycle.
- `flush_cnt` increments on every rule-2 cycle.
- All counters saturate at 2^CNT_W−1. `cnt_clr` has priority over increment and zeroes all three.
- Watchdog: `lock_run` counts consecutive rule-3 cycles. It is reset to 0 by any non-rule-3 cycle, except FREEZE cycles, which hold it. When `lock_run` reaches LOCK_MAX, `lock_err` is set. `lock_err` is cleared only by `rst_n`; `cnt_clr` does not affect it.

## Timing
- Reset values: state RUN, all counters 0, `lock_run` 0, `lock_err` 0.
- While `rst_n`=0: all `_we`=0, `pc_we`=0, `pc_sel`=0, flushes 0. Outputs are forced, not only the registers.
- On the first edge after release, behaviour is the normal rule evaluation from RUN.
- Control latency is zero: outputs respond combinationally to inputs in the same cycle.
- State, counters and `lock_err` update on the rising edge.
- Reset asserted mid-FREEZE or mid-STALL: the FSM returns to RUN and the counters are lost.
- `lock_err` rises on the edge ending the LOCK_MAX-th consecutive stall cycle.

## Structure
- Shared package `pipe_pkg`:
  - state enum `pipe_st_t` (RUN, STALL, FREEZE, REDIRECT);
  - a packed struct `stage_ctrl_t` holding all `_we`/flush/pc fields, so stage registers consume one bundle.
- One sub-module, `sat_counter`, parameterized by width, with `inc`/`clr` inputs. It is instantiated three times.
- The watchdog counter is inline.

## Test plan
- Idle: all inputs 0 after reset → `pc_we`=1, `pc_sel`=0, all `_we`=1, flushes 0, counters stay 0.
- `h_lock`=1 for 2 cycles → 2 cycles of `pc_we`=0, `if_rr_we`=0, `rr_ex_flush`=1; `stall_cnt`=2; then RUN outputs.
- `br_taken_ex` and `h_lock` both 1 → redirect (`pc_sel`=1, both flushes). Next cycle `h_lock`=1 is ignored; `flush_cnt`=1, `stall_cnt`=0.
- `mem_busy`=1 for 3 cycles with `br_taken_ex`=1 → 3 cycles all `_we`=0, `freeze_cnt`=3. On the 4th cycle (`mem_busy`=0) redirect asserts.
- LOCK_MAX=8: `h_lock` held 8 cycles → `lock_err`=1 after the 8th edge. It stays 1 through `cnt_clr`, and clears only on `rst_n`.
- CNT_W=4: 20 consecutive stalls → `stall_cnt` saturates at 15. A `cnt_clr` pulse → 0 next edge.
